// File: rtl/dtree_seq_eval.sv
// Sequential decision-tree classifier: walks a writable node table one comparison per clock.
// Optional depth guard enabled by defining DTREE_DEPTH_GUARD_EN.
module dtree_seq_eval #(
    parameter int NUM_FEATURES = 18,
    parameter int FEAT_W       = 8,
    parameter int NUM_NODES    = 64,
    parameter int CLASS_W      = 2,
    parameter int MAX_DEPTH    = 8,
    localparam int IDX_W   = $clog2(NUM_NODES),
    localparam int FSEL_W  = $clog2(NUM_FEATURES),
    localparam int PREC_W  = $clog2(FEAT_W + 1),
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1),
    localparam int NODE_W  = 1 + FSEL_W + PREC_W + FEAT_W + 2 * IDX_W
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           cfg_we_i,
    input  logic [IDX_W-1:0]               cfg_addr_i,
    input  logic [NODE_W-1:0]              cfg_wdata_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [NUM_FEATURES*FEAT_W-1:0] in_features_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [CLASS_W-1:0]             out_class_o,
    output logic [DEPTH_W-1:0]             out_depth_o,
    output logic                           out_err_o
);

    // state | meaning
    // IDLE  | ready for a feature vector; node table writable
    // WALK  | evaluating node[ptr] each cycle
    // DONE  | result held until out_ready
    typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} state_t;

    localparam int L_LSB    = IDX_W;
    localparam int T_LSB    = 2 * IDX_W;
    localparam int P_LSB    = T_LSB + FEAT_W;
    localparam int F_LSB    = P_LSB + PREC_W;
    localparam int LEAF_BIT = NODE_W - 1;

    localparam logic [NODE_W-1:0]  LEAF_ZERO = {1'b1, {(NODE_W-1){1'b0}}};
    localparam logic [IDX_W:0]     NODES_C   = (IDX_W+1)'(NUM_NODES);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
    localparam logic [PREC_W-1:0]  PREC_FULL = PREC_W'(FEAT_W);

    logic [NODE_W-1:0]              tbl_q [NUM_NODES];
    state_t                         state_q;
    logic [NUM_FEATURES*FEAT_W-1:0] feat_q;
    logic [IDX_W-1:0]               ptr_q;
    logic [IDX_W-1:0]               ptr_d;
    logic [DEPTH_W-1:0]             depth_q;
    logic                           in_ready_q;
    logic                           out_valid_q;
    logic [CLASS_W-1:0]             out_class_q;
    logic [DEPTH_W-1:0]             out_depth_q;

    logic [NODE_W-1:0] node_w;
    logic              n_leaf;
    logic [FSEL_W-1:0] n_feat;
    logic [PREC_W-1:0] n_prec;
    logic [FEAT_W-1:0] n_thr;
    logic [FEAT_W-1:0] x_sel;
    logic [FEAT_W-1:0] x_shr;
    logic [FEAT_W-1:0] thr_m;
    logic              take;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_NODES; i++) tbl_q[i] <= LEAF_ZERO;
        end else if (cfg_we_i && state_q == S_IDLE && {1'b0, cfg_addr_i} < NODES_C) begin
            tbl_q[cfg_addr_i] <= cfg_wdata_i;
        end
    end

    // Out-of-table pointers read as a class-0 leaf.
    always_comb begin
        node_w = LEAF_ZERO;
        if ({1'b0, ptr_q} < NODES_C) node_w = tbl_q[ptr_q];
    end

    assign n_leaf = node_w[LEAF_BIT];
    assign n_feat = node_w[F_LSB +: FSEL_W];
    assign n_prec = node_w[P_LSB +: PREC_W];
    assign n_thr  = node_w[T_LSB +: FEAT_W];

    always_comb begin
        x_sel = feat_q[FEAT_W-1:0];
        for (int f = 0; f < NUM_FEATURES; f++) begin
            if (n_feat == FSEL_W'(f)) x_sel = feat_q[f*FEAT_W +: FEAT_W];
        end
        // prec=0 shifts the feature out entirely and masks thr to zero, so take=1.
        x_shr = x_sel;
        thr_m = n_thr;
        if (n_prec < PREC_FULL) begin
            x_shr = x_sel >> (PREC_FULL - n_prec);
            thr_m = n_thr & ((FEAT_W'(1) << n_prec) - FEAT_W'(1));
        end
        take  = (x_shr <= thr_m);
        ptr_d = take ? node_w[L_LSB +: IDX_W] : node_w[IDX_W-1:0];
    end

`ifdef DTREE_DEPTH_GUARD_EN
    logic out_err_q;
    assign out_err_o = out_err_q;
`else
    assign out_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            feat_q      <= '0;
            ptr_q       <= '0;
            depth_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_depth_q <= '0;
`ifdef DTREE_DEPTH_GUARD_EN
            out_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        feat_q     <= in_features_i;
                        ptr_q      <= '0;
                        depth_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_WALK;
                    end
                end
                S_WALK: begin
                    if (n_leaf) begin
                        out_class_q <= n_thr[CLASS_W-1:0];
                        out_depth_q <= depth_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
`ifdef DTREE_DEPTH_GUARD_EN
                        out_err_q   <= 1'b0;
                    end else if (depth_q == DEPTH_MAX) begin
                        out_class_q <= '0;
                        out_depth_q <= DEPTH_MAX;
                        out_err_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
`endif
                    end else begin
                        ptr_q <= ptr_d;
                        if (depth_q != DEPTH_MAX) depth_q <= depth_q + DEPTH_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_class_o = out_class_q;
    assign out_depth_o = out_depth_q;

endmodule

// File: tb/tb_dtree_seq_eval.sv
// Bench for dtree_seq_eval: directed scenarios plus random acyclic trees checked against a tree-walk model.
module tb_dtree_seq_eval;
    localparam int NF = 18, FW = 8, NN = 64, CW = 2, MD = 8;
    localparam int IW = 6, FSW = 5, PW = 4, DW = 4, NW = 30;
`ifdef DTREE_DEPTH_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam logic [NW-1:0] LEAF0 = {1'b1, 29'b0};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [IW-1:0]    cfg_addr = '0;
    logic [NW-1:0]    cfg_wdata = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NF*FW-1:0] in_features = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CW-1:0]    out_class;
    logic [DW-1:0]    out_depth;
    logic             out_err;

    always #5 clk = ~clk;

    dtree_seq_eval #(.NUM_FEATURES(NF), .FEAT_W(FW), .NUM_NODES(NN), .CLASS_W(CW), .MAX_DEPTH(MD)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_features_i(in_features),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_class_o(out_class),
        .out_depth_o(out_depth), .out_err_o(out_err)
    );

    int checks = 0;
    int passed = 0;
    logic [NW-1:0] mdl [NN];

    function automatic logic [NW-1:0] mk_node(input bit leaf, input int feat, input int prec,
                                              input int thr, input int left, input int right);
        return {leaf, FSW'(feat), PW'(prec), FW'(thr), IW'(left), IW'(right)};
    endfunction

    function automatic logic [NF*FW-1:0] rand_feats();
        logic [NF*FW-1:0] f;
        for (int i = 0; i < NF; i++) f[i*FW +: FW] = FW'($urandom);
        return f;
    endfunction

    // Walk the table as software would; latency is comparisons + 1.
    function automatic void model(input logic [NF*FW-1:0] f, output int cls, output int dep,
                                  output int err, output int lat);
        int p, d, fi, x, prec, thr;
        bit take;
        logic [NW-1:0] w;
        p = 0; d = 0; cls = 0; dep = 0; err = 0; lat = -1;
        for (int step = 0; step < 1000; step++) begin
            w = (p < NN) ? mdl[p] : LEAF0;
            if (w[29]) begin
                cls = int'(w[19:12]) % (1 << CW);
                dep = (d > MD) ? MD : d;
                lat = d + 1;
                return;
            end
            if (GUARD && d == MD) begin
                cls = 0; dep = MD; err = 1; lat = MD + 1;
                return;
            end
            fi = int'(w[28:24]);
            if (fi >= NF) fi = 0;
            x = int'(f[fi*FW +: FW]);
            prec = int'(w[23:20]);
            thr = int'(w[19:12]);
            take = (prec == 0) ? 1'b1 : ((x >> (FW - prec)) <= (thr % (1 << prec)));
            p = take ? int'(w[11:6]) : int'(w[5:0]);
            d++;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NN; i++) mdl[i] = LEAF0;
    endtask

    task automatic write_node(input int addr, input logic [NW-1:0] w);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = IW'(addr); cfg_wdata = w;
        @(posedge clk);
        @(negedge clk);
        cfg_we = 1'b0;
        mdl[addr] = w;
    endtask

    task automatic accept(input logic [NF*FW-1:0] f, input bit we, input int addr, input logic [NW-1:0] w);
        @(negedge clk);
        in_features = f; in_valid = 1'b1;
        cfg_we = we; cfg_addr = IW'(addr); cfg_wdata = w;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic wait_out(output int c, output int d, output int e, output int lat);
        lat = 0;
        do begin
            @(posedge clk); lat++; @(negedge clk);
        end while (!out_valid && lat < 300);
        c = int'(out_class); d = int'(out_depth); e = int'(out_err);
    endtask

    task automatic finish_out(input int hold, input bit poke, output bit st, output bit idl);
        logic [CW-1:0] c0;
        logic [DW-1:0] d0;
        logic e0;
        c0 = out_class; d0 = out_depth; e0 = out_err;
        st = 1'b1;
        if (poke) in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            if (!out_valid || in_ready || out_class !== c0 || out_depth !== d0 || out_err !== e0) st = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        idl = in_ready && !out_valid;
    endtask

    task automatic send_vec(input logic [NF*FW-1:0] f, input int hold, input bit poke,
                            output int c, output int d, output int e, output int lat,
                            output bit st, output bit idl);
        accept(f, 1'b0, 0, '0);
        wait_out(c, d, e, lat);
        finish_out(hold, poke, st, idl);
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        checks++; if (out_class !== '0) $display("FAIL reset_out_class got %0d want 0", out_class); else passed++;
        checks++; if (out_depth !== '0) $display("FAIL reset_out_depth got %0d want 0", out_depth); else passed++;
        checks++; if (out_err !== 1'b0) $display("FAIL reset_out_err got %b want 0", out_err); else passed++;
    endtask

    task automatic load_basic();
        write_node(0, mk_node(0, 3, 2, 1, 1, 2));
        write_node(1, mk_node(1, 0, 0, 1, 0, 0));
        write_node(2, mk_node(1, 0, 0, 2, 0, 0));
    endtask

    task automatic test_basic();
        logic [NF*FW-1:0] f;
        int c, d, e, lat;
        bit st, idl;
        load_basic();
        f = '0; f[3*FW +: FW] = 8'h40;
        accept(f, 1'b0, 0, '0);
        checks++; if (in_ready !== 1'b0) $display("FAIL accept_in_ready got %b want 0", in_ready); else passed++;
        wait_out(c, d, e, lat);
        finish_out(0, 1'b0, st, idl);
        checks++; if (c != 1) $display("FAIL basic_lo_class got %0d want 1", c); else passed++;
        checks++; if (d != 1) $display("FAIL basic_lo_depth got %0d want 1", d); else passed++;
        checks++; if (lat != 2) $display("FAIL basic_lo_latency got %0d want 2", lat); else passed++;
        checks++; if (idl !== 1'b1) $display("FAIL basic_lo_idle got %b want 1", idl); else passed++;
        f[3*FW +: FW] = 8'hC0;
        send_vec(f, 0, 1'b0, c, d, e, lat, st, idl);
        checks++; if (c != 2) $display("FAIL basic_hi_class got %0d want 2", c); else passed++;
        checks++; if (d != 1) $display("FAIL basic_hi_depth got %0d want 1", d); else passed++;
        checks++; if (e != 0) $display("FAIL basic_hi_err got %0d want 0", e); else passed++;
    endtask

    task automatic test_backpressure();
        logic [NF*FW-1:0] f;
        int c, d, e, lat;
        bit st, idl;
        f = rand_feats(); f[3*FW +: FW] = 8'h7F;
        send_vec(f, 5, 1'b1, c, d, e, lat, st, idl);
        checks++; if (st !== 1'b1) $display("FAIL bp_stable got %b want 1", st); else passed++;
        checks++; if (idl !== 1'b1) $display("FAIL bp_idle_after_release got %b want 1", idl); else passed++;
        checks++; if (c != 1) $display("FAIL bp_class got %0d want 1", c); else passed++;
    endtask

    task automatic test_cfg_walk();
        logic [NF*FW-1:0] f;
        int c, d, e, lat;
        bit st, idl;
        f = '0; f[3*FW +: FW] = 8'h40;
        accept(f, 1'b0, 0, '0);
        cfg_we = 1'b1; cfg_addr = IW'(1); cfg_wdata = mk_node(1, 0, 0, 3, 0, 0);
        @(posedge clk); @(negedge clk);
        cfg_we = 1'b0;
        wait_out(c, d, e, lat);
        cfg_we = 1'b1; cfg_addr = IW'(2); cfg_wdata = mk_node(1, 0, 0, 3, 0, 0);
        @(posedge clk); @(negedge clk);
        cfg_we = 1'b0;
        finish_out(0, 1'b0, st, idl);
        checks++; if (c != 1) $display("FAIL cfg_walk_dropped got %0d want 1", c); else passed++;
        f[3*FW +: FW] = 8'hC0;
        send_vec(f, 0, 1'b0, c, d, e, lat, st, idl);
        checks++; if (c != 2) $display("FAIL cfg_done_dropped got %0d want 2", c); else passed++;
        write_node(1, mk_node(1, 0, 0, 3, 0, 0));
        f[3*FW +: FW] = 8'h40;
        send_vec(f, 0, 1'b0, c, d, e, lat, st, idl);
        checks++; if (c != 3) $display("FAIL cfg_idle_taken got %0d want 3", c); else passed++;
        accept(f, 1'b1, 1, mk_node(1, 0, 0, 2, 0, 0));
        mdl[1] = mk_node(1, 0, 0, 2, 0, 0);
        wait_out(c, d, e, lat);
        finish_out(0, 1'b0, st, idl);
        checks++; if (c != 2) $display("FAIL cfg_same_cycle got %0d want 2", c); else passed++;
        checks++; if (lat != 2) $display("FAIL cfg_same_cycle_lat got %0d want 2", lat); else passed++;
    endtask

    task automatic run_model_vec(input string tag, input int hold);
        logic [NF*FW-1:0] f;
        int c, d, e, lat, ec, ed, ee, el;
        bit st, idl;
        f = rand_feats();
        model(f, ec, ed, ee, el);
        send_vec(f, hold, 1'b0, c, d, e, lat, st, idl);
        checks++; if (c != ec) $display("FAIL %s_class got %0d want %0d", tag, c, ec); else passed++;
        checks++; if (d != ed) $display("FAIL %s_depth got %0d want %0d", tag, d, ed); else passed++;
        checks++; if (e != ee) $display("FAIL %s_err got %0d want %0d", tag, e, ee); else passed++;
        checks++; if (lat != el) $display("FAIL %s_latency got %0d want %0d", tag, lat, el); else passed++;
        checks++; if (st !== 1'b1 || idl !== 1'b1) $display("FAIL %s_handshake got %b%b want 11", tag, st, idl); else passed++;
    endtask

    task automatic test_depth_limit();
        for (int i = 0; i < MD; i++) write_node(i, mk_node(0, 0, 0, 0, i + 1, i + 1));
        write_node(MD, mk_node(1, 0, 0, 2, 0, 0));
        run_model_vec("depth_exact", 1);
        write_node(MD, mk_node(0, 0, 0, 0, MD + 1, MD + 1));
        write_node(MD + 1, mk_node(0, 5, 3, 255, MD + 2, MD + 2));
        write_node(MD + 2, mk_node(1, 0, 0, 3, 0, 0));
        run_model_vec("depth_over", 2);
`ifdef DTREE_DEPTH_GUARD_EN
        write_node(0, mk_node(0, 0, 0, 0, 0, 0));
        run_model_vec("guard_loop", 3);
`endif
    endtask

    task automatic test_random();
        logic [NW-1:0] w;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NN; i++) begin
                if (i >= 48 || $urandom_range(0, 3) == 0)
                    w = mk_node(1, $urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 255),
                                $urandom_range(0, 63), $urandom_range(0, 63));
                else
                    w = mk_node(0, $urandom_range(0, 19), $urandom_range(0, 8), $urandom_range(0, 255),
                                $urandom_range(i + 1, 63), $urandom_range(i + 1, 63));
                write_node(i, w);
            end
            for (int v = 0; v < 12; v++) run_model_vec("random", $urandom_range(0, 2));
        end
    endtask

    task automatic test_mid_reset();
        logic [NF*FW-1:0] f;
        int c, d, e, lat;
        bit st, idl;
        write_node(0, mk_node(1, 0, 0, 1, 0, 0));
        f = rand_feats();
        accept(f, 1'b0, 0, '0);
        wait_out(c, d, e, lat);
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_done_valid got %b want 0", out_valid); else passed++;
        checks++; if (out_class !== '0) $display("FAIL rst_done_class got %0d want 0", out_class); else passed++;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < NN; i++) mdl[i] = LEAF0;
        for (int i = 0; i < 10; i++) write_node(i, mk_node(0, 0, 0, 0, i + 1, i + 1));
        write_node(10, mk_node(1, 0, 0, 3, 0, 0));
        accept(f, 1'b0, 0, '0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_walk_valid got %b want 0", out_valid); else passed++;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < NN; i++) mdl[i] = LEAF0;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_walk_ready got %b want 1", in_ready); else passed++;
        send_vec(rand_feats(), 0, 1'b0, c, d, e, lat, st, idl);
        checks++; if (c != 0) $display("FAIL rst_table_class got %0d want 0", c); else passed++;
        checks++; if (d != 0) $display("FAIL rst_table_depth got %0d want 0", d); else passed++;
        checks++; if (lat != 1) $display("FAIL rst_table_latency got %0d want 1", lat); else passed++;
        checks++; if (e != 0) $display("FAIL rst_table_err got %0d want 0", e); else passed++;
    endtask

    initial begin
        do_reset();
        test_reset();
        test_basic();
        test_backpressure();
        test_cfg_walk();
        test_depth_limit();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
